// File: rtl/proc_pkg.sv
// Shared opcode definitions and state encoding for the memory-stage controller.
package proc_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;

    localparam logic [4:0] OP_LW = 5'b01000;
    localparam logic [4:0] OP_SW = 5'b00111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    function automatic logic [4:0] opcode_of(input logic [31:0] ins);
        return ins[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic is_mem_op(input logic [31:0] ins);
        return (opcode_of(ins) == OP_LW) || (opcode_of(ins) == OP_SW);
    endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// IDLE/BUSY request sequencer: drives stall and the request phase of the memory handshake.
// With MEM_TIMEOUT_EN defined, a wait counter aborts unanswered requests and sets sticky mem_err.
module mem_req_fsm
    import proc_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic is_mem,
    input  logic dmem_ack,
    output logic stall,
    output logic busy,
    output logic start,
    output logic done,
    output logic mem_err
);

    mem_state_e state_q, state_d;
    logic       timeout_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A timeout completes the request exactly like an ack, so upstream is released the same way.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        start   = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_mem) begin
                    stall   = 1'b1;
                    start   = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (dmem_ack || timeout_hit) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_BUSY);

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (start) begin
            wait_cnt_d = '0;
        end else if (busy) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // The counter holds the number of BUSY cycles already spent, so the last allowed cycle aborts.
    assign timeout_hit = busy && (wait_cnt_q == TIMEOUT_LAST);
    assign mem_err_d   = mem_err_q | (timeout_hit & ~dmem_ack);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign mem_err        = 1'b0;
`endif

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage: issues XM loads/stores over req/ack, stalls upstream, and registers MW results.
// Optional ack timeout with sticky mem_err is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl
    import proc_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              xm_valid,
    input  logic [31:0]       xm_o,
    input  logic [31:0]       xm_b,
    input  logic [31:0]       xm_ins,
    input  logic              xm_ovf,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              stall,
    output logic              mw_valid,
    output logic [31:0]       mw_o,
    output logic [31:0]       mw_d,
    output logic [31:0]       mw_ins,
    output logic              mw_ovf,
    output logic              mem_err
);

    logic is_mem;
    logic busy, start, done;

    logic [31:0] hold_o_q, hold_o_d;
    logic [31:0] hold_b_q, hold_b_d;
    logic [31:0] hold_ins_q, hold_ins_d;
    logic        hold_ovf_q, hold_ovf_d;
    logic        hold_we_q, hold_we_d;

    logic        mw_valid_q, mw_valid_d;
    logic [31:0] mw_o_q, mw_o_d;
    logic [31:0] mw_d_q, mw_d_d;
    logic [31:0] mw_ins_q, mw_ins_d;
    logic        mw_ovf_q, mw_ovf_d;

    assign is_mem = xm_valid && is_mem_op(xm_ins);

    mem_req_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_req_fsm (
        .clk      (clk),
        .reset_n  (reset_n),
        .is_mem   (is_mem),
        .dmem_ack (dmem_ack),
        .stall    (stall),
        .busy     (busy),
        .start    (start),
        .done     (done),
        .mem_err  (mem_err)
    );

    // MW defaults to a bubble; only a completed memory op or an idle non-memory op fills it.
    always_comb begin
        hold_o_d   = hold_o_q;
        hold_b_d   = hold_b_q;
        hold_ins_d = hold_ins_q;
        hold_ovf_d = hold_ovf_q;
        hold_we_d  = hold_we_q;
        mw_valid_d = 1'b0;
        mw_o_d     = '0;
        mw_d_d     = '0;
        mw_ins_d   = '0;
        mw_ovf_d   = 1'b0;

        if (start) begin
            hold_o_d   = xm_o;
            hold_b_d   = xm_b;
            hold_ins_d = xm_ins;
            hold_ovf_d = xm_ovf;
            hold_we_d  = (opcode_of(xm_ins) == OP_SW);
        end

        if (done) begin
            mw_valid_d = 1'b1;
            mw_o_d     = hold_o_q;
            mw_d_d     = (!hold_we_q && dmem_ack) ? dmem_rdata : '0;
            mw_ins_d   = hold_ins_q;
            mw_ovf_d   = hold_ovf_q;
        end else if (!busy && !is_mem) begin
            mw_valid_d = xm_valid;
            mw_o_d     = xm_o;
            mw_ins_d   = xm_ins;
            mw_ovf_d   = xm_ovf;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_o_q   <= '0;
            hold_b_q   <= '0;
            hold_ins_q <= '0;
            hold_ovf_q <= 1'b0;
            hold_we_q  <= 1'b0;
            mw_valid_q <= 1'b0;
            mw_o_q     <= '0;
            mw_d_q     <= '0;
            mw_ins_q   <= '0;
            mw_ovf_q   <= 1'b0;
        end else begin
            hold_o_q   <= hold_o_d;
            hold_b_q   <= hold_b_d;
            hold_ins_q <= hold_ins_d;
            hold_ovf_q <= hold_ovf_d;
            hold_we_q  <= hold_we_d;
            mw_valid_q <= mw_valid_d;
            mw_o_q     <= mw_o_d;
            mw_d_q     <= mw_d_d;
            mw_ins_q   <= mw_ins_d;
            mw_ovf_q   <= mw_ovf_d;
        end
    end

    assign dmem_req   = busy;
    assign dmem_we    = busy && hold_we_q;
    assign dmem_addr  = hold_o_q[ADDR_W-1:0];
    assign dmem_wdata = hold_b_q;

    assign mw_valid = mw_valid_q;
    assign mw_o     = mw_o_q;
    assign mw_d     = mw_d_q;
    assign mw_ins   = mw_ins_q;
    assign mw_ovf   = mw_ovf_q;

endmodule
